// File: rtl/in_buffer.sv
// Stream-to-random-access ingress buffer: de-interleaves X/Y(/M) body words into per-axis RAMs.
// Optional mass channel (third word per body, RD_M port) enabled by defining IN_BUFFER_MASS_EN.
module in_buffer #(
  parameter int N        = 256,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                CLEAR,
  input  logic [15:0]         DATA_IN,
  input  logic                D_VALID,
  output logic                D_READY,
  input  logic                RD_EN,
  input  logic [IDX_BITS-1:0] RD_IDX,
  output logic [15:0]         RD_X,
  output logic [15:0]         RD_Y,
`ifdef IN_BUFFER_MASS_EN
  output logic [15:0]         RD_M,
`endif
  output logic                RD_VALID,
  output logic [IDX_BITS:0]   BODY_CNT,
  output logic                FRAME_READY
);

`ifdef IN_BUFFER_MASS_EN
  localparam int PH_BITS = 2;
  localparam int WPB     = 3;
`else
  localparam int PH_BITS = 1;
  localparam int WPB     = 2;
`endif

  localparam logic [PH_BITS-1:0]  LAST_PH  = PH_BITS'(WPB - 1);
  localparam logic [PH_BITS-1:0]  PH_ONE   = 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = 1;
  localparam logic [IDX_BITS:0]   CNT_ONE  = 1;

  typedef enum logic {FILL, FULL} state_t;

  logic [15:0] x_mem [0:N-1];
  logic [15:0] y_mem [0:N-1];
`ifdef IN_BUFFER_MASS_EN
  logic [15:0] m_mem [0:N-1];
  logic [15:0] rd_m_q, rd_m_d;
  logic        m_we;
`endif

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] wr_idx_q, wr_idx_d;
  logic [PH_BITS-1:0]  phase_q, phase_d;
  logic                d_ready_q, d_ready_d;
  logic [IDX_BITS:0]   body_cnt_q, body_cnt_d;
  logic                frame_ready_q, frame_ready_d;
  logic [15:0]         rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic                rd_valid_q, rd_valid_d;
  logic                fire, wr_en, x_we, y_we;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    phase_d       = phase_q;
    d_ready_d     = d_ready_q;
    body_cnt_d    = body_cnt_q;
    frame_ready_d = frame_ready_q;
    fire          = D_VALID && d_ready_q;
    // CLEAR wins over a coincident word, so that word is neither stored nor counted
    wr_en         = fire && !CLEAR && (state_q == FILL);
    x_we          = wr_en && (phase_q == '0);
    y_we          = wr_en && (phase_q == PH_ONE);
`ifdef IN_BUFFER_MASS_EN
    m_we          = wr_en && (phase_q == LAST_PH);
`endif

    if (CLEAR) begin
      state_d       = FILL;
      wr_idx_d      = '0;
      phase_d       = '0;
      body_cnt_d    = '0;
      frame_ready_d = 1'b0;
      d_ready_d     = 1'b1;
    end else if (state_q == FILL) begin
      d_ready_d = 1'b1;
      if (fire) begin
        if (phase_q == LAST_PH) begin
          phase_d    = '0;
          body_cnt_d = body_cnt_q + CNT_ONE;
          if (wr_idx_q == LAST_IDX) begin
            state_d       = FULL;
            frame_ready_d = 1'b1;
            d_ready_d     = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
    end else begin
      d_ready_d     = 1'b0;
      frame_ready_d = 1'b1;
    end

    rd_valid_d = RD_EN;
    rd_x_d     = RD_EN ? x_mem[RD_IDX] : rd_x_q;
    rd_y_d     = RD_EN ? y_mem[RD_IDX] : rd_y_q;
`ifdef IN_BUFFER_MASS_EN
    rd_m_d     = RD_EN ? m_mem[RD_IDX] : rd_m_q;
`endif
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q       <= FILL;
      wr_idx_q      <= '0;
      phase_q       <= '0;
      d_ready_q     <= 1'b0;
      body_cnt_q    <= '0;
      frame_ready_q <= 1'b0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      rd_valid_q    <= 1'b0;
`ifdef IN_BUFFER_MASS_EN
      rd_m_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      phase_q       <= phase_d;
      d_ready_q     <= d_ready_d;
      body_cnt_q    <= body_cnt_d;
      frame_ready_q <= frame_ready_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      rd_valid_q    <= rd_valid_d;
`ifdef IN_BUFFER_MASS_EN
      rd_m_q        <= rd_m_d;
`endif
    end
  end

  // Storage has no reset so it maps onto block RAM; reads see pre-write contents
  always_ff @(posedge CLK_IN) begin
    if (x_we) x_mem[wr_idx_q] <= DATA_IN;
    if (y_we) y_mem[wr_idx_q] <= DATA_IN;
`ifdef IN_BUFFER_MASS_EN
    if (m_we) m_mem[wr_idx_q] <= DATA_IN;
`endif
  end

  assign D_READY     = d_ready_q;
  assign RD_X        = rd_x_q;
  assign RD_Y        = rd_y_q;
  assign RD_VALID    = rd_valid_q;
  assign BODY_CNT    = body_cnt_q;
  assign FRAME_READY = frame_ready_q;
`ifdef IN_BUFFER_MASS_EN
  assign RD_M        = rd_m_q;
`endif

endmodule
